stopwatch_counter: RTL



---
 rtl/stopwatch_counter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - MM:SS.hh BCD stopwatch counter with start/stop/clear FSM
// Optional lap display hold is built when STOPWATCH_LAP_EN is defined.
module stopwatch_counter #(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       base_tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       lap,
  output logic       timer_enb,
  output logic [3:0] hund_t,
  output logic [3:0] hund_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic       running,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVF} state_t;

  // Digit order in packed arrays: [0]=hund_u .. [5]=min_t
  localparam logic [5:0][3:0] DIGIT_MAX  = {4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
  localparam logic [5:0][3:0] MAX_DIGITS = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10),
                                            4'd5, 4'd9, 4'd9, 4'd9};

  state_t          state_q, state_d;
  logic [5:0][3:0] live_q, live_d, live_inc;
  logic            running_q, running_d;
  logic            overflow_q, overflow_d;
  logic            carry;
  logic            at_max;

  assign at_max = (live_q == MAX_DIGITS);

  always_comb begin
    live_inc = live_q;
    carry    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (live_q[i] == DIGIT_MAX[i]) begin
          live_inc[i] = 4'd0;
        end else begin
          live_inc[i] = live_q[i] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    live_d  = live_q;
    if (clear) begin
      state_d = IDLE;
      live_d  = '0;
    end else begin
      case (state_q)
        IDLE, PAUSE: if (start && !stop) state_d = RUN;
        RUN: begin
          if (stop) state_d = PAUSE;
          // Saturation takes precedence over a coincident stop
          if (base_tick) begin
            if (at_max) state_d = OVF;
            else        live_d  = live_inc;
          end
        end
        default: state_d = state_q;
      endcase
    end
    running_d  = (state_d == RUN);
    overflow_d = (state_d == OVF);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      live_q     <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_q     <= live_d;
      running_q  <= running_d;
      overflow_q <= overflow_d;
    end
  end

  assign running   = running_q;
  assign timer_enb = running_q;
  assign overflow  = overflow_q;

`ifdef STOPWATCH_LAP_EN
  logic            hold_q, hold_d;
  logic [5:0][3:0] shadow_q, shadow_d;
  logic [5:0][3:0] disp_q, disp_d;

  always_comb begin
    hold_d   = hold_q;
    shadow_d = shadow_q;
    if (clear || state_d == OVF) begin
      hold_d = 1'b0;
    end else if (lap && (state_q == RUN || state_q == PAUSE)) begin
      hold_d = !hold_q;
      if (!hold_q) shadow_d = live_q;
    end
    disp_d = hold_d ? shadow_d : live_d;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      hold_q   <= 1'b0;
      shadow_q <= '0;
      disp_q   <= '0;
    end else begin
      hold_q   <= hold_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
    end
  end

  assign {min_t, min_u, sec_t, sec_u, hund_t, hund_u} = disp_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign {min_t, min_u, sec_t, sec_u, hund_t, hund_u} = live_q;
`endif

endmodule
